// File: rtl/dac_seq_pkg.sv
// Shared types and width helpers for the DAC stream sequencer.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } dac_seq_state_t;

    localparam logic [7:0] UNDERRUN_MAX = 8'd255;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_stream_sequencer_if.sv
// Sample push handshake from the core into the sequencer FIFO.
interface dac_stream_sequencer_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CH_W   = 1
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_ch;

    modport master (output in_valid, output in_data, output in_ch, input in_ready);
    modport slave  (input in_valid, input in_data, input in_ch, output in_ready);
endinterface

// File: rtl/dac_seq_fifo.sv
// Synchronous power-of-two FIFO with registered full flag and occupancy.
module dac_seq_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q, level_d;
    logic             full_q;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && (level_q != '0);
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // full reads 1 in reset so the source is held off until the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
endmodule

// File: rtl/dac_stream_sequencer.sv
// Paced release of channel-tagged samples from a FIFO into per-channel DAC hold registers.
module dac_stream_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned DATA_W        = 10,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DIV_W         = 8,
    parameter bit          UNDERRUN_ZERO = 1'b0
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [DIV_W-1:0]                  rate_div,
    dac_stream_sequencer_if.slave             in_if,
    output logic [NUM_CH*DATA_W-1:0]          dac_d,
    output logic [NUM_CH-1:0]                 dac_upd,
    output logic [lvl_width(FIFO_DEPTH)-1:0]  fifo_level,
    output logic [7:0]                        underrun_cnt,
    output logic                              bad_ch,
    output logic                              busy
);
    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned ENT_W = DATA_W + CH_W;

    dac_seq_state_t            state_q;
    logic [DIV_W-1:0]          div_q;
    logic [NUM_CH*DATA_W-1:0]  dac_q;
    logic [NUM_CH-1:0]         upd_q;
    logic [7:0]                urun_q;
    logic                      bad_q;
    logic                      busy_q;

    logic                      push, pop, tick, ch_ok;
    logic                      fifo_full, fifo_empty;
    logic [ENT_W-1:0]          head;
    logic [CH_W-1:0]           head_ch;
    logic [DATA_W-1:0]         head_data;

    assign in_if.in_ready = ~fifo_full;

    always_comb begin
        push      = in_if.in_valid && in_if.in_ready;
        head_ch   = head[ENT_W-1 -: CH_W];
        head_data = head[DATA_W-1:0];
        tick      = (state_q != S_IDLE) && (div_q == '0);
        pop       = tick && !fifo_empty;
        ch_ok     = 32'(head_ch) < NUM_CH;
    end

    dac_seq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (reset),
        .push_i  (push),
        .wdata_i ({in_if.in_ch, in_if.in_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            dac_q   <= '0;
            upd_q   <= '0;
            urun_q  <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            upd_q <= '0;
            if (pop) begin
                if (ch_ok) begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (head_ch == CH_W'(k)) begin
                            dac_q[k*DATA_W +: DATA_W] <= head_data;
                            upd_q[k]                  <= 1'b1;
                        end
                    end
                end else begin
                    bad_q <= 1'b1;
                end
            end else if (tick && state_q == S_RUN) begin
                if (urun_q != UNDERRUN_MAX) urun_q <= urun_q + 8'd1;
                if (UNDERRUN_ZERO) dac_q <= '0;
            end

            // divider free-runs outside IDLE; the state cases below override it on entry/exit
            if (state_q != S_IDLE) div_q <= tick ? rate_div : div_q - DIV_W'(1);

            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_RUN;
                        div_q   <= rate_div;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!enable) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (enable) begin
                        state_q <= S_RUN;
                    end else if (tick && fifo_empty) begin
                        state_q <= S_IDLE;
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    div_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dac_d        = dac_q;
    assign dac_upd      = upd_q;
    assign underrun_cnt = urun_q;
    assign bad_ch       = bad_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Directed bench: a 3-channel zero-on-underrun instance and a 2-channel hold instance share stimulus.
module tb_dac_stream_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] rate_div;
    logic       valid;
    logic [9:0] data;
    logic [1:0] ch;

    logic [29:0] d3;
    logic [2:0]  upd3;
    logic [3:0]  lvl3;
    logic [7:0]  urun3;
    logic        bad3, busy3;
    logic [19:0] d2;
    logic [1:0]  upd2;
    logic [3:0]  lvl2;
    logic [7:0]  urun2;
    logic        bad2, busy2;

    int n_pass  = 0;
    int n_total = 0;

    dac_stream_sequencer_if #(.DATA_W(10), .CH_W(2)) if3 ();
    dac_stream_sequencer_if #(.DATA_W(10), .CH_W(1)) if2 ();

    assign if3.in_valid = valid;
    assign if3.in_data  = data;
    assign if3.in_ch    = ch;
    assign if2.in_valid = valid;
    assign if2.in_data  = data;
    assign if2.in_ch    = ch[0];

    dac_stream_sequencer #(
        .DATA_W(10), .NUM_CH(3), .FIFO_DEPTH(8), .DIV_W(8), .UNDERRUN_ZERO(1'b1)
    ) dut3 (
        .CLK(clk), .reset(rst), .enable(enable), .rate_div(rate_div), .in_if(if3),
        .dac_d(d3), .dac_upd(upd3), .fifo_level(lvl3), .underrun_cnt(urun3),
        .bad_ch(bad3), .busy(busy3)
    );

    dac_stream_sequencer #(
        .DATA_W(10), .NUM_CH(2), .FIFO_DEPTH(8), .DIV_W(8), .UNDERRUN_ZERO(1'b0)
    ) dut2 (
        .CLK(clk), .reset(rst), .enable(enable), .rate_div(rate_div), .in_if(if2),
        .dac_d(d2), .dac_upd(upd2), .fifo_level(lvl2), .underrun_cnt(urun2),
        .bad_ch(bad2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [9:0]  data;
        logic [2:0]  upd;
        logic [29:0] d;
        logic        bad;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [1:0] c, input logic [9:0] v);
        valid = 1'b1;
        ch    = c;
        data  = v;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        valid  = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int idle_at;
        int offs [3];

        rst = 1'b1; enable = 1'b0; rate_div = '0; valid = 1'b0; data = '0; ch = '0;

        tbl[0] = '{2'd0, 10'h155, 3'b001, {10'h000, 10'h000, 10'h155}, 1'b0};
        tbl[1] = '{2'd1, 10'h2AA, 3'b010, {10'h000, 10'h2AA, 10'h155}, 1'b0};
        tbl[2] = '{2'd2, 10'h3FF, 3'b100, {10'h3FF, 10'h2AA, 10'h155}, 1'b0};
        tbl[3] = '{2'd3, 10'h123, 3'b000, {10'h3FF, 10'h2AA, 10'h155}, 1'b1};
        tbl[4] = '{2'd0, 10'h001, 3'b001, {10'h3FF, 10'h2AA, 10'h001}, 1'b1};
        tbl[5] = '{2'd2, 10'h080, 3'b100, {10'h080, 10'h2AA, 10'h001}, 1'b1};

        // reset values and release
        repeat (2) @(negedge clk);
        chk("rst_dac_d", 32'(d3), 32'h0);
        chk("rst_dac_upd", 32'(upd3), 32'h0);
        chk("rst_level", 32'(lvl3), 32'h0);
        chk("rst_underrun", 32'(urun3), 32'h0);
        chk("rst_bad_ch", 32'(bad3), 32'h0);
        chk("rst_busy", 32'(busy3), 32'h0);
        chk("rst_in_ready", 32'(if3.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 32'(if3.in_ready), 32'h0);
        @(negedge clk);
        chk("ready_after_edge", 32'(if3.in_ready), 32'h1);

        // table: queue all vectors, then release at one per cycle
        for (int i = 0; i < 6; i++) push(tbl[i].ch, tbl[i].data);
        chk("tbl_level", 32'(lvl3), 32'd6);
        rate_div = 8'd0;
        enable   = 1'b1;
        @(negedge clk);
        chk("tbl_busy", 32'(busy3), 32'h1);
        chk("tbl_no_early_upd", 32'(upd3), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_upd", i), 32'(upd3), 32'(tbl[i].upd));
            chk($sformatf("tbl%0d_d", i), 32'(d3), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_bad", i), 32'(bad3), 32'(tbl[i].bad));
        end
        @(negedge clk);
        chk("tbl_underrun", 32'(urun3), 32'd1);
        chk("tbl_zeroed", 32'(d3), 32'h0);
        chk("tbl_underrun_upd", 32'(upd3), 32'h0);
        chk("tbl_hold_d2", 32'(d2), 32'({10'h123, 10'h080}));
        chk("tbl_underrun2", 32'(urun2), 32'd1);
        do_reset();

        // paced output, rate_div = 3
        rate_div = 8'd3;
        push(2'd0, 10'h155);
        push(2'd1, 10'h2AA);
        enable = 1'b1;
        @(negedge clk);
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (upd3 != '0) pulses++;
            if (upd2 != '0) pulses++;
            if (k == 4) begin
                chk("paced_upd3_e4", 32'(upd3), 32'b001);
                chk("paced_upd2_e4", 32'(upd2), 32'b01);
            end
            if (k == 8) begin
                chk("paced_upd3_e8", 32'(upd3), 32'b010);
                chk("paced_upd2_e8", 32'(upd2), 32'b10);
                chk("paced_d3", 32'(d3[19:0]), 32'({10'h2AA, 10'h155}));
                chk("paced_d2", 32'(d2), 32'({10'h2AA, 10'h155}));
            end
        end
        chk("paced_pulses", 32'(pulses), 32'd4);
        do_reset();

        // full / backpressure, then reset mid-RUN at level 5
        for (int i = 0; i < 8; i++) push(2'(i % 3), 10'h100 + 10'(i));
        chk("full_level", 32'(lvl3), 32'd8);
        chk("full_ready", 32'(if3.in_ready), 32'h0);
        valid = 1'b1; ch = 2'd2; data = 10'h3AB;
        repeat (2) @(negedge clk);
        chk("full_9th_rejected", 32'(lvl3), 32'd8);
        rate_div = 8'd0;
        enable   = 1'b1;
        @(negedge clk);
        chk("full_ready_e0", 32'(if3.in_ready), 32'h0);
        @(negedge clk);
        chk("full_level_e1", 32'(lvl3), 32'd7);
        chk("full_ready_e1", 32'(if3.in_ready), 32'h1);
        chk("full_upd_e1", 32'(upd3), 32'b001);
        chk("full_d_e1", 32'(d3[9:0]), 32'h100);
        @(negedge clk);
        chk("pushpop_level", 32'(lvl3), 32'd7);
        chk("full_d_e2", 32'(d3[19:10]), 32'h101);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_level5", 32'(lvl3), 32'd5);
        rst = 1'b1;
        #1;
        chk("midrun_rst_level", 32'(lvl3), 32'h0);
        chk("midrun_rst_d", 32'(d3), 32'h0);
        chk("midrun_rst_busy", 32'(busy3), 32'h0);
        chk("midrun_rst_ready", 32'(if3.in_ready), 32'h0);
        do_reset();

        // underrun saturation
        push(2'd0, 10'h155);
        push(2'd1, 10'h2AA);
        rate_div = 8'd0;
        enable   = 1'b1;
        repeat (300) @(negedge clk);
        chk("sat_underrun3", 32'(urun3), 32'd255);
        chk("sat_underrun2", 32'(urun2), 32'd255);
        chk("sat_zero_d3", 32'(d3), 32'h0);
        chk("sat_hold_d2", 32'(d2), 32'({10'h2AA, 10'h155}));
        do_reset();

        // drain on disable
        rate_div = 8'd2;
        push(2'd0, 10'h011);
        push(2'd1, 10'h022);
        push(2'd2, 10'h033);
        enable = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        pulses  = 0;
        idle_at = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (upd3 != '0) begin
                if (pulses < 3) offs[pulses] = k;
                pulses++;
            end
            if (busy3 == 1'b0 && idle_at == 0) idle_at = k;
        end
        chk("drain_pulses", 32'(pulses), 32'd3);
        chk("drain_off0", 32'(offs[0]), 32'd3);
        chk("drain_off1", 32'(offs[1]), 32'd6);
        chk("drain_off2", 32'(offs[2]), 32'd9);
        chk("drain_idle_at", 32'(idle_at), 32'd12);
        chk("drain_underrun", 32'(urun3), 32'd0);
        chk("drain_d", 32'(d3), 32'({10'h033, 10'h022, 10'h011}));
        chk("drain_level", 32'(lvl3), 32'd0);
        do_reset();

        // push coinciding with a tick on an empty FIFO
        rate_div = 8'd2;
        enable   = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        valid = 1'b1; ch = 2'd0; data = 10'h2C3;
        @(negedge clk);
        valid = 1'b0;
        chk("coinc_underrun", 32'(urun3), 32'd1);
        chk("coinc_level", 32'(lvl3), 32'd1);
        chk("coinc_no_upd", 32'(upd3), 32'h0);
        repeat (3) @(negedge clk);
        chk("coinc_upd_next", 32'(upd3), 32'b001);
        chk("coinc_d_next", 32'(d3[9:0]), 32'h2C3);
        chk("coinc_level_next", 32'(lvl3), 32'd0);
        chk("coinc_underrun_next", 32'(urun3), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
